// File: rtl/fpu_mul_arbiter.sv
// Round-robin front end that shares one multiplier among NUM_REQ requesters.
// One operation in flight: grant in IDLE, hold operands in EXEC, then return the result in RESP.
module fpu_mul_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 3,
    parameter int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [32*NUM_REQ-1:0]   req_data1,
    input  logic [32*NUM_REQ-1:0]   req_data2,
    output logic [31:0]             mul_data1,
    output logic [31:0]             mul_data2,
    input  logic [31:0]             mul_result,
    input  logic                    mul_overflow,
    input  logic                    mul_underflow,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [31:0]             resp_result,
    output logic                    resp_overflow,
    output logic                    resp_underflow,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int CW = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Handshakes: a request transfers on the edge where req_valid[i] & req_ready[i];
    // a response transfers on the edge where resp_valid & resp_ready.
    state_t             r_state;
    logic [IDW-1:0]     r_last_grant;
    logic [CW-1:0]      r_cnt;
    logic [31:0]        r_mul_data1;
    logic [31:0]        r_mul_data2;
    logic               r_resp_valid;
    logic [IDW-1:0]     r_resp_id;
    logic [31:0]        r_resp_result;
    logic               r_resp_overflow;
    logic               r_resp_underflow;
    logic               r_busy;

    logic               w_found;
    logic [IDW-1:0]     w_cand;
    logic [IDW-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0] w_grant_oh;
    logic [31:0]        w_sel_data1;
    logic [31:0]        w_sel_data2;
    logic               w_accept;

    // Search upward from the requester after the last winner, wrapping around.
    always_comb begin
        w_found     = 1'b0;
        w_cand      = '0;
        w_grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDW'((int'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_grant_oh  = '0;
        w_sel_data1 = '0;
        w_sel_data2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_idx == IDW'(i)) begin
                w_grant_oh[i] = w_found;
                w_sel_data1   = req_data1[32*i +: 32];
                w_sel_data2   = req_data2[32*i +: 32];
            end
        end
    end

    assign w_accept  = (r_state == IDLE) && w_found;
    assign req_ready = (r_state == IDLE) ? w_grant_oh : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state          <= IDLE;
            r_last_grant     <= IDW'(NUM_REQ - 1);
            r_cnt            <= '0;
            r_mul_data1      <= '0;
            r_mul_data2      <= '0;
            r_resp_valid     <= 1'b0;
            r_resp_id        <= '0;
            r_resp_result    <= '0;
            r_resp_overflow  <= 1'b0;
            r_resp_underflow <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mul_data1  <= w_sel_data1;
                        r_mul_data2  <= w_sel_data2;
                        r_resp_id    <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                        r_cnt        <= CW'(MUL_LATENCY);
                        r_state      <= EXEC;
                        r_busy       <= 1'b1;
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt - 1'b1;
                    // Last cycle of the multiplier latency: its outputs are valid now.
                    if (r_cnt == CW'(1)) begin
                        r_resp_result    <= mul_result;
                        r_resp_overflow  <= mul_overflow;
                        r_resp_underflow <= mul_underflow;
                        r_resp_valid     <= 1'b1;
                        r_state          <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign mul_data1      = r_mul_data1;
    assign mul_data2      = r_mul_data2;
    assign resp_valid     = r_resp_valid;
    assign resp_id        = r_resp_id;
    assign resp_result    = r_resp_result;
    assign resp_overflow  = r_resp_overflow;
    assign resp_underflow = r_resp_underflow;
    assign busy           = r_busy;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: a 4-requester/latency-3 instance and a 2-requester/latency-1 instance,
// each driven against a multiplier model whose output is only valid in the last latency cycle.
module tb_fpu_mul_arbiter;

    localparam int ML  = 3;
    localparam int ML2 = 1;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    // 4-requester instance
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_data1 = '0;
    logic [127:0] req_data2 = '0;
    logic [31:0]  mul_data1, mul_data2, mul_result;
    logic         mul_overflow, mul_underflow;
    logic         resp_valid, resp_overflow, resp_underflow, busy;
    logic         resp_ready = 1'b0;
    logic [1:0]   resp_id, dbg_state;
    logic [31:0]  resp_result;

    // 2-requester instance
    logic [1:0]   b_req_valid = '0;
    logic [1:0]   b_req_ready;
    logic [63:0]  b_req_data1 = '0;
    logic [63:0]  b_req_data2 = '0;
    logic [31:0]  b_mul_data1, b_mul_data2, b_mul_result;
    logic         b_mul_overflow, b_mul_underflow;
    logic         b_resp_valid, b_resp_overflow, b_resp_underflow, b_busy;
    logic         b_resp_ready = 1'b0;
    logic [0:0]   b_resp_id;
    logic [1:0]   b_dbg_state;
    logic [31:0]  b_resp_result;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [35:0] exp_q[$];
    logic [34:0] exp2_q[$];
    logic [31:0] op_a[4];
    logic [31:0] op_b[4];

    fpu_mul_arbiter #(.NUM_REQ(4), .MUL_LATENCY(ML)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2),
        .mul_data1(mul_data1), .mul_data2(mul_data2),
        .mul_result(mul_result), .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_overflow(resp_overflow), .resp_underflow(resp_underflow),
        .busy(busy), .dbg_state(dbg_state)
    );

    fpu_mul_arbiter #(.NUM_REQ(2), .MUL_LATENCY(ML2)) dut2 (
        .CLK(CLK), .nRST(nRST),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_data1(b_req_data1), .req_data2(b_req_data2),
        .mul_data1(b_mul_data1), .mul_data2(b_mul_data2),
        .mul_result(b_mul_result), .mul_overflow(b_mul_overflow), .mul_underflow(b_mul_underflow),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_id(b_resp_id),
        .resp_result(b_resp_result), .resp_overflow(b_resp_overflow), .resp_underflow(b_resp_underflow),
        .busy(b_busy), .dbg_state(b_dbg_state)
    );

    // Multiplier model: returns {overflow, underflow, product}
    function automatic logic [33:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3FC00000 && b == 32'h40000000) return {2'b00, 32'h40400000};
        if (a == 32'h7F000000 && b == 32'h40000000) return {2'b10, 32'h7F800000};
        if (a == 32'h00800000 && b == 32'h00800000) return {2'b01, 32'h00000000};
        return {2'b00, a ^ {b[15:0], b[31:16]}};
    endfunction

    // Cycles since the operands were accepted; the model output is valid only in the last one.
    int   m_cnt = 100;
    int   b_cnt = 100;
    logic m_hs  = 1'b0;
    logic b_hs  = 1'b0;
    logic [33:0] m_out, b_out;

    always @(posedge CLK) cyc++;
    always @(negedge CLK) begin
        m_hs <= |(req_valid & req_ready);
        b_hs <= |(b_req_valid & b_req_ready);
    end
    always @(posedge CLK) begin
        m_cnt <= m_hs ? 0 : ((m_cnt < 100) ? m_cnt + 1 : m_cnt);
        b_cnt <= b_hs ? 0 : ((b_cnt < 100) ? b_cnt + 1 : b_cnt);
    end
    always_comb begin
        m_out = fmul_model(mul_data1, mul_data2);
        if (m_cnt != ML - 1) m_out = {2'b11, 32'hDEADBEEF};
        b_out = fmul_model(b_mul_data1, b_mul_data2);
        if (b_cnt != ML2 - 1) b_out = {2'b11, 32'hDEADBEEF};
    end
    assign {mul_overflow, mul_underflow, mul_result}       = m_out;
    assign {b_mul_overflow, b_mul_underflow, b_mul_result} = b_out;

    // Scoreboards: compare each response in the cycle it is accepted.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected got id=%0d res=%h", resp_id, resp_result);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({resp_id, resp_overflow, resp_underflow, resp_result} !== e) begin
                    n_fail++;
                    $display("FAIL resp_data got %h required %h",
                             {resp_id, resp_overflow, resp_underflow, resp_result}, e);
                end
            end
        end
        if (nRST === 1'b1 && b_resp_valid === 1'b1 && b_resp_ready === 1'b1) begin
            n_checks++;
            if (exp2_q.size() == 0) begin
                n_fail++;
                $display("FAIL b_resp_unexpected got id=%0d res=%h", b_resp_id, b_resp_result);
            end else begin
                logic [34:0] e2;
                e2 = exp2_q.pop_front();
                if ({b_resp_id, b_resp_overflow, b_resp_underflow, b_resp_result} !== e2) begin
                    n_fail++;
                    $display("FAIL b_resp_data got %h required %h",
                             {b_resp_id, b_resp_overflow, b_resp_underflow, b_resp_result}, e2);
                end
            end
        end
    end

    task automatic set_slot(input int i, input logic [31:0] a, input logic [31:0] b);
        op_a[i] = a;
        op_b[i] = b;
        req_data1[32*i +: 32] = a;
        req_data2[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 1'b0;
        req_valid = '0; resp_ready = 1'b0; b_req_valid = '0; b_resp_ready = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic wait_grant(input int idx);
        int t = 0;
        @(negedge CLK);
        while (req_ready[idx] !== 1'b1 && t < 30) begin
            @(negedge CLK);
            t++;
        end
        n_checks++;
        if (t >= 30) begin
            n_fail++;
            $display("FAIL grant_timeout req_ready=%b required bit %0d", req_ready, idx);
        end
    endtask

    task automatic wait_resp();
        int t = 0;
        @(negedge CLK);
        while (resp_valid !== 1'b1 && t < 30) begin
            @(negedge CLK);
            t++;
        end
        n_checks++;
        if (t >= 30) begin
            n_fail++;
            $display("FAIL resp_timeout resp_valid=%b required 1", resp_valid);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || exp2_q.size() != 0) && t < 60) begin
            @(posedge CLK);
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0 || exp2_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d/%0d required 0/0", exp_q.size(), exp2_q.size());
        end
    endtask

    task automatic test_reset();
        @(posedge CLK); @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({req_ready, busy, resp_valid, resp_id, resp_overflow, resp_underflow, dbg_state} !== '0 ||
            mul_data1 !== '0 || mul_data2 !== '0 || resp_result !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b rv=%b md1=%h res=%h required all 0",
                     busy, resp_valid, mul_data1, resp_result);
        end
        n_checks++;
        if ({b_req_ready, b_busy, b_resp_valid, b_resp_id} !== '0 || b_mul_data1 !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_b got busy=%b rv=%b required 0", b_busy, b_resp_valid);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 4'b0000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req got req_ready=%b busy=%b required 0000/0", req_ready, busy);
        end
    endtask

    task automatic test_single_op();
        @(posedge CLK); #1;
        set_slot(0, 32'h3FC00000, 32'h40000000);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        exp_q.push_back({2'd0, 2'b00, 32'h40400000});
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_grant got %b required 0001", req_ready);
        end
        @(posedge CLK); #1;
        req_valid = '0;
        for (int c = 1; c <= ML; c++) begin
            if (c > 1) @(negedge CLK);
            else @(negedge CLK);
            n_checks++;
            if (mul_data1 !== 32'h3FC00000 || mul_data2 !== 32'h40000000 || resp_valid !== 1'b0 ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL exec_hold cycle %0d got md1=%h md2=%h rv=%b rr=%b busy=%b", c,
                         mul_data1, mul_data2, resp_valid, req_ready, busy);
            end
        end
        @(negedge CLK);
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_result !== 32'h40400000) begin
            n_fail++;
            $display("FAIL single_resp got rv=%b id=%0d res=%h required 1/0/40400000",
                     resp_valid, resp_id, resp_result);
        end
        @(negedge CLK);
        n_checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done got busy=%b rv=%b required 0/0", busy, resp_valid);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        int last_cyc = 0;
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_slot(i, 32'h3F800000 | (i << 4), 32'h40000000 | (i << 8));
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            int g = order[n];
            int t = 0;
            exp_q.push_back({2'(g), fmul_model(op_a[g], op_b[g])});
            @(negedge CLK);
            while (req_ready === 4'b0000 && t < 30) begin
                @(negedge CLK);
                t++;
            end
            n_checks++;
            if (req_ready !== 4'(1 << g)) begin
                n_fail++;
                $display("FAIL rr_grant step %0d got %b required %b", n, req_ready, 4'(1 << g));
            end
            if (n > 0) begin
                n_checks++;
                if (cyc - last_cyc != ML + 2) begin
                    n_fail++;
                    $display("FAIL rr_interval got %0d required %0d", cyc - last_cyc, ML + 2);
                end
            end
            last_cyc = cyc;
        end
        @(posedge CLK); #1;
        req_valid = '0;
        drain();
    endtask

    task automatic test_backpressure();
        logic [33:0] m1;
        @(posedge CLK); #1;
        resp_ready = 1'b0;
        set_slot(1, 32'h12345678, 32'h0BADF00D);
        set_slot(2, 32'h40490FDB, 32'h3F000000);
        m1 = fmul_model(op_a[1], op_b[1]);
        req_valid = 4'b0010;
        exp_q.push_back({2'd1, m1});
        wait_grant(1);
        @(posedge CLK); #1;
        req_valid = 4'b0100;
        wait_resp();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge CLK);
            n_checks++;
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_result !== m1[31:0] ||
                req_ready !== 4'b0000 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold k=%0d got rv=%b id=%0d res=%h rr=%b required 1/1/%h/0000",
                         k, resp_valid, resp_id, resp_result, req_ready, m1[31:0]);
            end
        end
        @(posedge CLK); #1;
        resp_ready = 1'b1;
        exp_q.push_back({2'd2, fmul_model(op_a[2], op_b[2])});
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_no_grant_in_resp got %b required 0000", req_ready);
        end
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_grant_after got %b required 0100", req_ready);
        end
        @(posedge CLK); #1;
        req_valid = '0;
        drain();
    endtask

    task automatic test_flags();
        @(posedge CLK); #1;
        resp_ready = 1'b1;
        set_slot(3, 32'h7F000000, 32'h40000000);
        req_valid = 4'b1000;
        exp_q.push_back({2'd3, 2'b10, 32'h7F800000});
        wait_grant(3);
        @(posedge CLK); #1;
        req_valid = '0;
        wait_resp();
        n_checks++;
        if (resp_overflow !== 1'b1 || resp_underflow !== 1'b0 || resp_result !== 32'h7F800000) begin
            n_fail++;
            $display("FAIL flags_ovf got ovf=%b unf=%b res=%h required 1/0/7F800000",
                     resp_overflow, resp_underflow, resp_result);
        end
        @(posedge CLK); #1;
        set_slot(0, 32'h00800000, 32'h00800000);
        req_valid = 4'b0001;
        exp_q.push_back({2'd0, 2'b01, 32'h00000000});
        wait_grant(0);
        @(posedge CLK); #1;
        req_valid = '0;
        wait_resp();
        n_checks++;
        if (resp_overflow !== 1'b0 || resp_underflow !== 1'b1 || resp_result !== 32'h00000000) begin
            n_fail++;
            $display("FAIL flags_unf got ovf=%b unf=%b res=%h required 0/1/00000000",
                     resp_overflow, resp_underflow, resp_result);
        end
        drain();
    endtask

    task automatic test_reset_mid_exec();
        int seen = 0;
        @(posedge CLK); #1;
        set_slot(1, 32'hCAFEF00D, 32'h13579BDF);
        req_valid = 4'b0010;
        wait_grant(1);
        @(posedge CLK); #1;
        req_valid = '0;
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, busy, resp_valid, resp_id, dbg_state} !== '0 ||
            mul_data1 !== '0 || mul_data2 !== '0 || resp_result !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs got busy=%b md1=%h md2=%h rv=%b required all 0",
                     busy, mul_data1, mul_data2, resp_valid);
        end
        @(posedge CLK); #1;
        nRST = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (resp_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_resp got %0d valid cycles required 0", seen);
        end
        @(posedge CLK); #1;
        for (int i = 0; i < 4; i++) set_slot(i, 32'h3F800000 + i, 32'h41000000 + i);
        req_valid = 4'hF;
        exp_q.push_back({2'd0, fmul_model(op_a[0], op_b[0])});
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_next_grant got %b required 0001", req_ready);
        end
        @(posedge CLK); #1;
        req_valid = '0;
        drain();
    endtask

    task automatic test_edge_params();
        @(posedge CLK); #1;
        b_resp_ready = 1'b1;
        b_req_data1 = {32'h3E800000, 32'h44AA55AA};
        b_req_data2 = {32'h40A00000, 32'h0F0F1234};
        b_req_valid = 2'b11;
        exp2_q.push_back({1'b0, fmul_model(32'h44AA55AA, 32'h0F0F1234)});
        @(negedge CLK);
        n_checks++;
        if (b_req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL edge_first_grant got %b required 01", b_req_ready);
        end
        @(posedge CLK); #1;
        b_req_valid = 2'b01;
        b_req_data1[31:0] = 32'h3F000001;
        b_req_data2[31:0] = 32'h3F000002;
        exp2_q.push_back({1'b0, fmul_model(32'h3F000001, 32'h3F000002)});
        @(negedge CLK);
        n_checks++;
        if (b_resp_valid !== 1'b0 || b_mul_data1 !== 32'h44AA55AA || b_mul_data2 !== 32'h0F0F1234) begin
            n_fail++;
            $display("FAIL edge_exec got rv=%b md1=%h md2=%h required 0/44aa55aa/0f0f1234",
                     b_resp_valid, b_mul_data1, b_mul_data2);
        end
        @(negedge CLK);
        n_checks++;
        if (b_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL edge_latency got rv=%b required 1", b_resp_valid);
        end
        @(negedge CLK);
        n_checks++;
        if (b_req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL edge_skip got %b required 01", b_req_ready);
        end
        @(posedge CLK); #1;
        b_req_valid = '0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_flags();
        test_reset_mid_exec();
        test_edge_params();
        repeat (3) @(posedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
